sram_arbiter: RTL and testbench

SRAM_ARBITER -- requirements
Module: sram_arbiter

---
 rtl/sram_arbiter.sv | 104 ++++++++++
 tb/tb_sram_arbiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/sram_arbiter.sv
// sram_arbiter: one single-port 32-bit SRAM shared by an instruction read port
// and a data read/write port. Data wins conflicts, except that inst is granted
// once it has lost MAX_STARVE consecutive cycles. Read data is registered and
// appears one cycle after the grant, accompanied by a one-cycle rvalid pulse.
module sram_arbiter #(
    parameter int ADDR_W     = 12,
    parameter int MAX_STARVE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [31:0] inst_sram_addr,
    output logic [31:0] inst_sram_rdata,
    output logic        inst_rvalid,
    output logic        inst_stall,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_we,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic        data_rvalid,
    output logic        data_stall
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int SW    = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(MAX_STARVE);

    logic [31:0]       mem_q [DEPTH];
    logic [SW-1:0]     starve_q, starve_d;
    logic [31:0]       inst_rdata_q, data_rdata_q;
    logic              inst_rvalid_q, data_rvalid_q;
    logic              gnt_inst, gnt_data, data_wr, data_rd;
    logic [ADDR_W-1:0] iidx, didx, acc_idx;
    logic [31:0]       rd_word, wr_word;
    logic              unused_addr;

    // Word index drops the byte offset; upper address bits alias.
    assign iidx    = inst_sram_addr[ADDR_W+1:2];
    assign didx    = data_sram_addr[ADDR_W+1:2];
    assign unused_addr = ^{inst_sram_addr[31:ADDR_W+2], inst_sram_addr[1:0],
                           data_sram_addr[31:ADDR_W+2], data_sram_addr[1:0]};

    // Grant decision: nothing during reset, data wins unless inst is starved.
    always_comb begin
        gnt_inst = 1'b0;
        gnt_data = 1'b0;
        if (reset) begin
            if (inst_sram_en && (!data_sram_en || starve_q == STARVE_LIM))
                gnt_inst = 1'b1;
            else if (data_sram_en)
                gnt_data = 1'b1;
        end
    end

    assign data_wr    = gnt_data && (data_sram_we != 4'h0);
    assign data_rd    = gnt_data && (data_sram_we == 4'h0);
    assign inst_stall = inst_sram_en && reset && !gnt_inst;
    assign data_stall = data_sram_en && reset && !gnt_data;

    // The single array port: one word is addressed per cycle by the winner.
    assign acc_idx = gnt_inst ? iidx : didx;
    assign rd_word = mem_q[acc_idx];

    // Byte-merge for partial writes (read-modify-write on the same port).
    always_comb begin
        wr_word = rd_word;
        for (int b = 0; b < 4; b++)
            if (data_sram_we[b]) wr_word[8*b +: 8] = data_sram_wdata[8*b +: 8];
    end

    // Starvation counter: counts consecutive inst stalls, saturating.
    always_comb begin
        starve_d = '0;
        if (inst_stall)
            starve_d = (starve_q == STARVE_LIM) ? starve_q : starve_q + 1'b1;
    end

    // Array storage: written only by a granted data write, never reset.
    always_ff @(posedge clk) begin
        if (data_wr) mem_q[acc_idx] <= wr_word;
    end

    // Registered read data, rvalid pulses and starvation state.
    always_ff @(posedge clk) begin
        if (!reset) begin
            inst_rdata_q  <= 32'h0;
            data_rdata_q  <= 32'h0;
            inst_rvalid_q <= 1'b0;
            data_rvalid_q <= 1'b0;
            starve_q      <= '0;
        end else begin
            inst_rvalid_q <= gnt_inst;
            data_rvalid_q <= data_rd;
            starve_q      <= starve_d;
            if (gnt_inst) inst_rdata_q <= rd_word;
            if (data_rd)  data_rdata_q <= rd_word;
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign inst_rvalid     = inst_rvalid_q;
    assign data_sram_rdata = data_rdata_q;
    assign data_rvalid     = data_rvalid_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: cycle-by-cycle reference model with a read-data
// scoreboard per port, directed scenarios plus a random traffic phase.
module tb_sram_arbiter;
    localparam int MAXS = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        inst_sram_en, data_sram_en;
    logic [31:0] inst_sram_addr, data_sram_addr, data_sram_wdata;
    logic [3:0]  data_sram_we;
    logic [31:0] inst_sram_rdata, data_sram_rdata;
    logic        inst_rvalid, data_rvalid, inst_stall, data_stall;

    sram_arbiter #(.ADDR_W(12), .MAX_STARVE(MAXS)) dut (
        .clk(clk), .reset(reset),
        .inst_sram_en(inst_sram_en), .inst_sram_addr(inst_sram_addr),
        .inst_sram_rdata(inst_sram_rdata), .inst_rvalid(inst_rvalid),
        .inst_stall(inst_stall),
        .data_sram_en(data_sram_en), .data_sram_we(data_sram_we),
        .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
        .data_sram_rdata(data_sram_rdata), .data_rvalid(data_rvalid),
        .data_stall(data_stall)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] mem_m [4096];
    int          starve_m = 0;
    logic [31:0] last_i = 32'h0, last_d = 32'h0;
    logic [31:0] iq[$], dq[$];
    logic        gi, gd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive, check stalls, advance the model, check outputs.
    task automatic cyc(input logic rst, input logic ie, input logic [31:0] ia,
                       input logic de, input logic [3:0] we,
                       input logic [31:0] da, input logic [31:0] wd);
        logic [31:0] w;
        reset = rst; inst_sram_en = ie; inst_sram_addr = ia;
        data_sram_en = de; data_sram_we = we; data_sram_addr = da; data_sram_wdata = wd;
        #2;
        gi = rst && ie && (!de || starve_m == MAXS);
        gd = rst && de && !gi;
        chk("inst_stall", {31'b0, inst_stall}, {31'b0, ie && rst && !gi});
        chk("data_stall", {31'b0, data_stall}, {31'b0, de && rst && !gd});
        if (gi) iq.push_back(mem_m[ia[13:2]]);
        if (gd && we == 4'h0) dq.push_back(mem_m[da[13:2]]);
        if (gd && we != 4'h0) begin
            w = mem_m[da[13:2]];
            for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
            mem_m[da[13:2]] = w;
        end
        if (!rst) starve_m = 0;
        else if (ie && !gi) starve_m = (starve_m == MAXS) ? MAXS : starve_m + 1;
        else starve_m = 0;
        @(posedge clk); #1;
        chk("inst_rvalid", {31'b0, inst_rvalid}, {31'b0, gi});
        chk("data_rvalid", {31'b0, data_rvalid}, {31'b0, gd && we == 4'h0});
        if (!rst) begin last_i = 32'h0; last_d = 32'h0; end
        if (gi && iq.size() > 0) last_i = iq.pop_front();
        if (gd && we == 4'h0 && dq.size() > 0) last_d = dq.pop_front();
        chk("inst_rdata", inst_sram_rdata, last_i);
        chk("data_rdata", data_sram_rdata, last_d);
    endtask

    task automatic idle();
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0] a, b, r;
        int nst;
        // Reset with both requesting: no grants, no stalls, outputs cleared.
        cyc(1'b0, 1'b1, 32'h10, 1'b1, 4'hF, 32'h10, 32'h1234);
        cyc(1'b0, 1'b1, 32'h10, 1'b1, 4'h0, 32'h10, 32'h0);
        // Preload words 0..15 through the data port.
        for (int i = 0; i < 16; i++)
            cyc(1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 32'(i * 4), 32'hA5000000 + 32'(i * 32'h111));
        // Full write then read back.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);
        chk("full_write", data_sram_rdata, 32'hDEADBEEF);
        // Single-byte write merges into the existing word.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 4'b0010, 32'h10, 32'h0000AA00);
        chk("wr_keeps_rdata", data_sram_rdata, 32'hDEADBEEF);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h10, 32'h0);
        chk("byte_merge", data_sram_rdata, 32'hDEADAAEF);
        // Conflict: data wins first, inst served once data drops.
        cyc(1'b1, 1'b1, 32'h10, 1'b1, 4'h0, 32'h20, 32'h0);
        cyc(1'b1, 1'b1, 32'h10, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("inst_after_conflict", inst_sram_rdata, 32'hDEADAAEF);
        idle();
        // Continuous conflict: inst loses MAX_STARVE cycles, then wins once.
        nst = 0;
        for (int c = 0; c < 2 * (MAXS + 1); c++) begin
            cyc(1'b1, 1'b1, 32'h8, 1'b1, 4'h0, 32'(c * 4), 32'h0);
            if (c < MAXS + 1 && gi == 1'b0) nst++;
        end
        chk("starve_window", 32'(nst), 32'(MAXS));
        idle();
        // Aliasing: upper address bits are ignored.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 32'h10, 32'hCAFEF00D);
        cyc(1'b1, 1'b1, 32'h4010, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("alias_read", inst_sram_rdata, 32'hCAFEF00D);
        // Back-to-back alternating grants with no bubble.
        cyc(1'b1, 1'b1, 32'h4, 1'b0, 4'h0, 32'h0, 32'h0);
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 4'h0, 32'h8, 32'h0);
        cyc(1'b1, 1'b1, 32'hC, 1'b0, 4'h0, 32'h0, 32'h0);
        // Random traffic over the preloaded words with random alias bits.
        for (int c = 0; c < 300; c++) begin
            a = $urandom(); b = $urandom(); r = $urandom();
            a[13:6] = 8'h0; b[13:6] = 8'h0;
            cyc(1'b1, r[0], a, r[1], (r[2] && r[3]) ? r[7:4] : 4'h0, b, $urandom());
        end
        idle();
        // Reset in the cycle after a granted read; array survives reset.
        cyc(1'b1, 1'b0, 32'h0, 1'b1, 4'hF, 32'h30, 32'h600DF00D);
        cyc(1'b1, 1'b1, 32'h30, 1'b1, 4'h0, 32'h30, 32'h0);
        cyc(1'b0, 1'b1, 32'h30, 1'b1, 4'h0, 32'h30, 32'h0);
        chk("rst_data_rdata", data_sram_rdata, 32'h0);
        chk("rst_data_rvalid", {31'b0, data_rvalid}, 32'h0);
        cyc(1'b1, 1'b1, 32'h30, 1'b0, 4'h0, 32'h0, 32'h0);
        chk("post_rst_word", inst_sram_rdata, 32'h600DF00D);
        idle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
